// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, default bit divisor and data width.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int DATA_BITS        = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw RX line plus a falling-edge detector.
// All flops reset to the idle (high) line level so reset never fakes a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rxd_i,
   output logic rxd_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // synchroniser chain and one-cycle history of the synced line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rxd_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rxd_o  = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: start validation, mid-bit sampling, stop check and a
// pulse-request / ack handshake towards the receive FIFO.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_rxd,
   input  logic                 i_fifo_ack,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_fifo_rq,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_rx_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic                 rxd_s;
   logic                 fall_s;
   logic                 good_s;
   logic                 pend_eff_s;

   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 rq_q, rq_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 busy_q, busy_d;
   logic                 pending_q, pending_d;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .rxd_i  (i_rxd),
      .rxd_o  (rxd_s),
      .fall_o (fall_s)
   );

   // state, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         shift_q   <= '0;
         data_q    <= '0;
         rq_q      <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         busy_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         rq_q      <= rq_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         busy_q    <= busy_d;
         pending_q <= pending_d;
      end
   end

   // next-state, sampling and handshake decisions
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      rq_d      = 1'b0;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      good_s    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall_s) state_d = START;
            else        state_d = IDLE;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               idx_d = 3'd0;
               if (!rxd_s) state_d = DATA;
               else        state_d = IDLE;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
               else                             state_d = DATA;
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rxd_s) begin
                  good_s  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               state_d = STOP;
            end
         end
         BREAK: begin
            // a held-low line must return high before a new start is accepted
            cnt_d = '0;
            if (rxd_s) state_d = IDLE;
            else       state_d = BREAK;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // an ack arriving with the completing frame frees the slot first
      pend_eff_s = pending_q & ~i_fifo_ack;
      pending_d  = pend_eff_s;
      if (good_s) begin
         if (!pend_eff_s) begin
            rq_d      = 1'b1;
            data_d    = shift_q;
            pending_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else begin
         pending_d = pend_eff_s;
      end

      busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
   end

   assign o_rx_data   = data_q;
   assign o_fifo_rq   = rq_q;
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;
   assign o_rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: vector table, corner-case sequences and
// randomized frames scored against a frame-level handshake model.
module tb_uart_rx_core;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_rxd = 1'b1;
   logic       i_fifo_ack = 1'b0;
   logic [7:0] o_rx_data;
   logic       o_fifo_rq;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_rx_busy;

   always #5 clk = ~clk;

   uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rxd       (i_rxd),
      .i_fifo_ack  (i_fifo_ack),
      .o_rx_data   (o_rx_data),
      .o_fifo_rq   (o_fifo_rq),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_rx_busy   (o_rx_busy)
   );

   int total = 0;
   int bad   = 0;

   // event counters sampled on the falling edge
   int         rq_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, unstable_cnt = 0;
   logic [7:0] last_rq_data = 8'h00;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_data <= o_rx_data;
      end else begin
         if (o_fifo_rq) begin
            rq_cnt       <= rq_cnt + 1;
            last_rq_data <= o_rx_data;
         end else if (o_rx_data != prev_data) begin
            unstable_cnt <= unstable_cnt + 1;
         end
         prev_data <= o_rx_data;
         if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
         if (o_overrun)   ovr_cnt  <= ovr_cnt + 1;
         if (o_rx_busy)   busy_cnt <= busy_cnt + 1;
      end
   end

   bit auto_ack = 1'b1;
   int ack_cnt  = 0;

   // one clock; inputs change 1 time unit after the edge; auto-ack 2 cycles after a request
   task automatic tick();
      @(posedge clk);
      #1;
      i_fifo_ack = 1'b0;
      if (ack_cnt > 0) begin
         ack_cnt--;
         if (ack_cnt == 0) i_fifo_ack = 1'b1;
      end
      if (o_fifo_rq && auto_ack) ack_cnt = 2;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_range(input string name, input int got, input int lo, input int hi);
      total++;
      if (got < lo || got > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   // start bit, 8 data bits LSB first, stop bit, then gap idle cycles; ack forced at cycle ack_at
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap, input int ack_at);
      logic [9:0] bits;
      int cyc = 0;
      bits = {stop_bit, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         i_rxd = bits[b];
         for (int k = 0; k < CPB; k++) begin
            if (cyc == ack_at) i_fifo_ack = 1'b1;
            tick();
            cyc++;
         end
      end
      for (int g = 0; g < gap; g++) begin
         i_rxd = 1'b1;
         tick();
      end
   endtask

   task automatic run_frame(input string name, input logic [7:0] d, input logic stop_bit,
                            input int gap, input int ack_at, input int exp_rq,
                            input int exp_ferr, input int exp_ovr, input logic [7:0] exp_data);
      int r0 = rq_cnt, f0 = ferr_cnt, o0 = ovr_cnt, b0 = busy_cnt;
      send_frame(d, stop_bit, gap, ack_at);
      chk({name, ".rq"}, rq_cnt - r0, exp_rq);
      chk({name, ".ferr"}, ferr_cnt - f0, exp_ferr);
      chk({name, ".ovr"}, ovr_cnt - o0, exp_ovr);
      chk({name, ".data"}, int'(o_rx_data), int'(exp_data));
      if (exp_rq != 0) chk({name, ".rqdata"}, int'(last_rq_data), int'(d));
      chk_range({name, ".busy"}, busy_cnt - b0, 9 * CPB, 10 * CPB);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      int         gap;
      bit         auto;
      bit         pre_ack;
      int         exp_rq;
      int         exp_ferr;
      int         exp_ovr;
      logic [7:0] exp_held;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int r0, f0, b0;
      bit pending_m;
      logic [7:0] held_m;

      tbl[0] = '{8'hA5, 1'b1,  5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
      tbl[1] = '{8'h55, 1'b1,  0, 1'b1, 1'b0, 1, 0, 0, 8'h55};
      tbl[2] = '{8'hAA, 1'b1,  0, 1'b1, 1'b0, 1, 0, 0, 8'hAA};
      tbl[3] = '{8'hFF, 1'b1, 20, 1'b1, 1'b0, 1, 0, 0, 8'hFF};
      tbl[4] = '{8'h3C, 1'b0, 20, 1'b1, 1'b0, 0, 1, 0, 8'hFF};
      tbl[5] = '{8'h11, 1'b1,  5, 1'b1, 1'b0, 1, 0, 0, 8'h11};
      tbl[6] = '{8'h01, 1'b1,  5, 1'b0, 1'b0, 1, 0, 0, 8'h01};
      tbl[7] = '{8'h02, 1'b1,  5, 1'b0, 1'b0, 0, 0, 1, 8'h01};
      tbl[8] = '{8'h03, 1'b1,  5, 1'b1, 1'b1, 1, 0, 0, 8'h03};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst.data", int'(o_rx_data), 0);
      chk("rst.rq", int'(o_fifo_rq), 0);
      chk("rst.ferr", int'(o_frame_err), 0);
      chk("rst.ovr", int'(o_overrun), 0);
      chk("rst.busy", int'(o_rx_busy), 0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("idle.busy", int'(o_rx_busy), 0);

      // vector table
      for (int i = 0; i < 9; i++) begin
         auto_ack = tbl[i].auto;
         if (tbl[i].pre_ack) begin
            i_fifo_ack = 1'b1;
            tick();
         end
         run_frame($sformatf("vec%0d", i), tbl[i].data, tbl[i].stop_ok, tbl[i].gap, -1,
                   tbl[i].exp_rq, tbl[i].exp_ferr, tbl[i].exp_ovr, tbl[i].exp_held);
      end

      // glitch: short low pulse is rejected at the start-bit sample
      r0 = rq_cnt; f0 = ferr_cnt; b0 = busy_cnt;
      i_rxd = 1'b0;
      repeat (4) tick();
      i_rxd = 1'b1;
      repeat (30) tick();
      chk("glitch.rq", rq_cnt - r0, 0);
      chk("glitch.ferr", ferr_cnt - f0, 0);
      chk_range("glitch.busy", busy_cnt - b0, 0, CPB / 2 + 1);
      chk("glitch.data", int'(o_rx_data), 8'h03);

      // break: bad stop bit, line held low for 100 cycles
      auto_ack = 1'b1;
      r0 = rq_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 0, -1);
      b0 = busy_cnt;
      repeat (100) tick();
      chk("break.ferr", ferr_cnt - f0, 1);
      chk("break.rq", rq_cnt - r0, 0);
      chk("break.busy", busy_cnt - b0, 0);
      i_rxd = 1'b1;
      repeat (10) tick();
      run_frame("after_break", 8'h11, 1'b1, 5, -1, 1, 0, 0, 8'h11);

      // ack coincides with the stop-bit sample of the next good frame
      auto_ack = 1'b0;
      run_frame("pend", 8'h5A, 1'b1, 5, -1, 1, 0, 0, 8'h5A);
      run_frame("ack_same", 8'hC3, 1'b1, 5, 10 * CPB - 6, 1, 0, 0, 8'hC3);
      i_fifo_ack = 1'b1;
      tick();

      // reset during data bit 4 of 0x77
      auto_ack = 1'b1;
      begin
         logic [9:0] bits;
         bits = {1'b1, 8'h77, 1'b0};
         for (int c = 0; c < 5 * CPB + CPB / 4; c++) begin
            i_rxd = bits[c / CPB];
            tick();
         end
      end
      chk("midrst.busy_before", int'(o_rx_busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst.data", int'(o_rx_data), 0);
      chk("midrst.rq", int'(o_fifo_rq), 0);
      chk("midrst.ferr", int'(o_frame_err), 0);
      chk("midrst.ovr", int'(o_overrun), 0);
      chk("midrst.busy", int'(o_rx_busy), 0);
      tick();
      tick();
      i_rxd = 1'b1;
      rst_n = 1'b1;
      r0 = rq_cnt;
      repeat (200) tick();
      chk("midrst.no_rq", rq_cnt - r0, 0);
      run_frame("after_rst", 8'h42, 1'b1, 5, -1, 1, 0, 0, 8'h42);

      // randomized frames against the frame-level model
      pending_m = 1'b0;
      held_m    = 8'h42;
      for (int i = 0; i < 12; i++) begin
         logic [7:0] d;
         logic       stop_ok;
         bit         pre;
         int         gap, e_rq, e_ferr, e_ovr;
         d        = 8'($urandom);
         stop_ok  = ($urandom_range(0, 3) != 0);
         auto_ack = ($urandom_range(0, 1) == 1);
         pre      = ($urandom_range(0, 2) == 0);
         gap      = stop_ok ? $urandom_range(0, 12) : $urandom_range(4, 12);
         if (pre) begin
            i_fifo_ack = 1'b1;
            tick();
            pending_m = 1'b0;
         end
         e_rq = 0; e_ferr = 0; e_ovr = 0;
         if (!stop_ok) begin
            e_ferr = 1;
         end else if (pending_m) begin
            e_ovr = 1;
         end else begin
            e_rq      = 1;
            held_m    = d;
            pending_m = !auto_ack;
         end
         run_frame($sformatf("rnd%0d", i), d, stop_ok, gap, -1, e_rq, e_ferr, e_ovr, held_m);
      end

      chk("data_stable", unstable_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
